ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 34 +++
 rtl/ps2_host_tx.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encoding, error codes, common command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_NOACK   = 2'd2;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  // Odd parity bit: makes the total count of ones over data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a falling-edge
// detector on the clock. Idle lines are high, so all stages reset to 1.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic clk_fall_o
);

  logic [1:0] clk_meta_q;
  logic [1:0] data_meta_q;
  logic       clk_prev_q;

  // Synchronizer chains and previous-clock register for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_meta_q  <= 2'b11;
      data_meta_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_meta_q  <= {clk_meta_q[0], ps2_clk_i};
      data_meta_q <= {data_meta_q[0], ps2_data_i};
      clk_prev_q  <= clk_meta_q[1];
    end
  end

  assign clk_s_o    = clk_meta_q[1];
  assign data_s_o   = data_meta_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_meta_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter with open-drain pull-low enables,
// device-clock watchdog and ACK check. All outputs are registered.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int FIRST_TIMEOUT  = 1500000,
  parameter int BIT_TIMEOUT    = 200000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  output logic [1:0] ERR_CODE
);

  localparam int IN_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int WD_W = $clog2(FIRST_TIMEOUT + 1);
  localparam logic [IN_W-1:0] INH_LAST   = IN_W'(INHIBIT_CYCLES - 1);
  localparam logic [IN_W-1:0] INH_PRE    = IN_W'(INHIBIT_CYCLES - 2);
  localparam logic [WD_W-1:0] FIRST_LAST = WD_W'(FIRST_TIMEOUT - 1);
  localparam logic [WD_W-1:0] BIT_LAST   = WD_W'(BIT_TIMEOUT - 1);

  // Watchdog counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
    return (v == {WD_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic clk_s, data_s, clk_fall;

  ps2_line_sync u_sync (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .ps2_clk_i  (PS2_CLK_IN),
    .ps2_data_i (PS2_DATA_IN),
    .clk_s_o    (clk_s),
    .data_s_o   (data_s),
    .clk_fall_o (clk_fall)
  );

  ps2_state_t      state_q, state_d;
  logic [8:0]      shift_q, shift_d;
  logic [3:0]      bit_q, bit_d;
  logic [IN_W-1:0] inh_q, inh_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            watch, timeout;
  logic [WD_W-1:0] wd_lim;

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      inh_q     <= '0;
      wdog_q    <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      inh_q     <= inh_d;
      wdog_q    <= wdog_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  // Next-state logic: watchdog first, then per-state sequencing, timeout overrides last.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    inh_d     = inh_q;
    wdog_d    = wdog_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    timeout   = 1'b0;

    // Before the first device edge the long limit applies, afterwards the per-bit one.
    wd_lim = (state_q == RTS) ? FIRST_LAST : BIT_LAST;
    watch  = (state_q == RTS) || (state_q == SHIFT) ||
             (state_q == ACK) || (state_q == WAIT_IDLE);
    if (watch) begin
      if (clk_fall)               wdog_d  = '0;
      else if (wdog_q >= wd_lim)  timeout = 1'b1;
      else                        wdog_d  = sat_inc(wdog_q);
    end

    case (state_q)
      IDLE: begin
        if (TX_START) begin
          state_d   = INHIBIT;
          shift_d   = {odd_parity(TX_DATA), TX_DATA};
          bit_d     = '0;
          inh_d     = '0;
          wdog_d    = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          busy_d    = 1'b1;
          ack_d     = 1'b0;
          code_d    = ERR_NONE;
        end
      end
      INHIBIT: begin
        inh_d = inh_q + 1'b1;
        // Start bit goes low in the final inhibit cycle, just before clock release.
        if (inh_q == INH_PRE) data_oe_d = 1'b1;
        if (inh_q == INH_LAST) begin
          state_d  = RTS;
          clk_oe_d = 1'b0;
          wdog_d   = '0;
        end
      end
      RTS: begin
        if (clk_fall) begin
          state_d   = SHIFT;
          bit_d     = 4'd1;
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[8:1]};
        end
      end
      SHIFT: begin
        if (clk_fall) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          bit_d   = bit_q + 4'd1;
          ack_d   = ~data_s;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = ack_q;
          err_d   = ~ack_q;
          code_d  = ack_q ? ERR_NONE : ERR_NOACK;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d   = IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
      code_d    = ERR_TIMEOUT;
    end
  end

  assign PS2_CLK_OE  = clk_oe_q;
  assign PS2_DATA_OE = data_oe_q;
  assign TX_BUSY     = busy_q;
  assign TX_DONE     = done_q;
  assign TX_ERR      = err_q;
  assign ERR_CODE    = code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a behavioural PS/2 device.
module tb_ps2_host_tx;

  localparam int INH   = 20;
  localparam int FIRST = 400;
  localparam int BITTO = 120;
  localparam int H     = 10;   // device half clock period in CLK cycles

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_START = 1'b0;
  logic       PS2_CLK_OE, PS2_DATA_OE, TX_BUSY, TX_DONE, TX_ERR;
  logic [1:0] ERR_CODE;

  logic dev_clk = 1'b1;
  logic dev_data_low = 1'b0;
  logic ps2_clk, ps2_data;
  assign ps2_clk  = ~PS2_CLK_OE & dev_clk;
  assign ps2_data = ~PS2_DATA_OE & ~dev_data_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .FIRST_TIMEOUT  (FIRST),
    .BIT_TIMEOUT    (BITTO)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .TX_DATA     (TX_DATA),
    .TX_START    (TX_START),
    .PS2_CLK_IN  (ps2_clk),
    .PS2_DATA_IN (ps2_data),
    .PS2_CLK_OE  (PS2_CLK_OE),
    .PS2_DATA_OE (PS2_DATA_OE),
    .TX_BUSY     (TX_BUSY),
    .TX_DONE     (TX_DONE),
    .TX_ERR      (TX_ERR),
    .ERR_CODE    (ERR_CODE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Event monitor sampled on the inactive edge.
  int n_done = 0, n_err = 0, n_both = 0, oe_cnt = 0, err_cyc = 0;
  logic [1:0] last_code = 2'd0;
  always @(negedge CLK) begin
    if (TX_DONE) n_done++;
    if (TX_ERR) begin
      n_err++;
      err_cyc   = cyc;
      last_code = ERR_CODE;
    end
    if (TX_DONE && TX_ERR) n_both++;
    if (PS2_CLK_OE) oe_cnt++;
  end

  int total = 0, bad = 0;
  logic [10:0] dev_bits;
  int rts_cyc = 0, fall_cyc = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    TX_DATA  = b;
    TX_START = 1'b1;
    step(1);
    TX_START = 1'b0;
  endtask

  // Reference frame as seen on the wire: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Device: waits for request-to-send, then clocks up to stop_after edges,
  // sampling on rising edges; optionally ACKs on edge 11 or pulses RESET at rst_edge.
  task automatic dev_xfer(input int stop_after, input bit ack_low, input int rst_edge);
    int g;
    dev_bits = '1;
    g = 0;
    while (!PS2_CLK_OE && g < 200) begin step(1); g++; end
    if (!PS2_CLK_OE) begin check_eq("inhibit_seen", 0, 1); return; end
    g = 0;
    while (PS2_CLK_OE && g < 200) begin step(1); g++; end
    if (PS2_CLK_OE) begin check_eq("clk_release", 0, 1); return; end
    rts_cyc = cyc;
    step(2);
    dev_bits[0] = ps2_data;
    for (int k = 1; k <= 11; k++) begin
      if (k > stop_after) return;
      if (k == 11 && ack_low) dev_data_low = 1'b1;
      step(H);
      dev_clk  = 1'b0;
      fall_cyc = cyc;
      if (k == rst_edge) begin
        step(1);
        RESET = 1'b1;
        step(1);
        check_eq("rst_clk_oe", int'(PS2_CLK_OE), 0);
        check_eq("rst_data_oe", int'(PS2_DATA_OE), 0);
        check_eq("rst_busy", int'(TX_BUSY), 0);
        RESET   = 1'b0;
        dev_clk = 1'b1;
        return;
      end
      step(H);
      if (k <= 10) dev_bits[k] = ps2_data;
      dev_clk      = 1'b1;
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_not_busy(input string tag);
    int g;
    g = 0;
    while (TX_BUSY && g < 2000) begin step(1); g++; end
    check_eq(tag, int'(TX_BUSY), 0);
    step(2);
  endtask

  task automatic wait_err(input int e0, input int bound);
    int g;
    g = 0;
    while (n_err == e0 && g < bound) begin step(1); g++; end
    check_eq("err_seen", n_err - e0, 1);
  endtask

  task automatic full_xfer(input logic [7:0] b);
    int d0, e0, o0;
    logic [10:0] exp_f;
    d0 = n_done; e0 = n_err; o0 = oe_cnt;
    exp_f = frame_of(b);
    send(b);
    dev_xfer(11, 1'b1, 0);
    wait_not_busy("busy_clear");
    check_eq("frame", int'(dev_bits), int'(exp_f));
    check_eq("decoded", int'(dev_bits[8:1]), int'(b));
    check_eq("parity", int'(dev_bits[9]), int'(exp_f[9]));
    check_eq("inhibit_len", oe_cnt - o0, INH);
    check_eq("done_pulses", n_done - d0, 1);
    check_eq("err_pulses", n_err - e0, 0);
    check_eq("err_code_ok", int'(ERR_CODE), 0);
  endtask

  initial begin
    int d0, e0;
    logic [7:0] rb;

    RESET = 1'b1;
    step(4);
    check_eq("reset_clk_oe", int'(PS2_CLK_OE), 0);
    check_eq("reset_data_oe", int'(PS2_DATA_OE), 0);
    check_eq("reset_busy", int'(TX_BUSY), 0);
    check_eq("reset_done", int'(TX_DONE), 0);
    check_eq("reset_err", int'(TX_ERR), 0);
    check_eq("reset_code", int'(ERR_CODE), 0);
    RESET = 1'b0;
    step(2);

    // Named commands and parity corner cases.
    full_xfer(8'hED);
    full_xfer(8'h02);
    full_xfer(8'hF4);
    full_xfer(8'hFF);
    full_xfer(8'h00);

    // Random bytes.
    for (int r = 0; r < 5; r++) begin
      rb = 8'($urandom_range(0, 255));
      full_xfer(rb);
    end

    // Device never clocks after release.
    d0 = n_done; e0 = n_err;
    send(8'($urandom_range(0, 255)));
    dev_xfer(0, 1'b1, 0);
    wait_err(e0, FIRST + 200);
    check_eq("first_to_lat", err_cyc - rts_cyc, FIRST);
    check_eq("first_to_code", int'(last_code), 1);
    check_eq("first_to_clk_oe", int'(PS2_CLK_OE), 0);
    check_eq("first_to_data_oe", int'(PS2_DATA_OE), 0);
    check_eq("first_to_busy", int'(TX_BUSY), 0);
    check_eq("first_to_nodone", n_done - d0, 0);

    // Device stops after edge 5, then a clean transfer follows.
    d0 = n_done; e0 = n_err;
    send(8'($urandom_range(0, 255)));
    dev_xfer(5, 1'b1, 0);
    wait_err(e0, BITTO + 200);
    check_eq("bit_to_lat", err_cyc - fall_cyc, BITTO + 3);
    check_eq("bit_to_code", int'(ERR_CODE), 1);
    check_eq("bit_to_busy", int'(TX_BUSY), 0);
    check_eq("bit_to_nodone", n_done - d0, 0);
    step(5);
    full_xfer(8'hF4);

    // No ACK on edge 11.
    d0 = n_done; e0 = n_err;
    send(8'($urandom_range(0, 255)));
    dev_xfer(11, 1'b0, 0);
    wait_not_busy("noack_busy");
    check_eq("noack_err", n_err - e0, 1);
    check_eq("noack_nodone", n_done - d0, 0);
    check_eq("noack_code", int'(last_code), 2);
    check_eq("noack_code_held", int'(ERR_CODE), 2);

    // Start while busy must not re-latch data.
    d0 = n_done;
    send(8'hA5);
    step(3);
    send(8'h5A);
    dev_xfer(11, 1'b1, 0);
    wait_not_busy("busy_start_clear");
    check_eq("busy_start_byte", int'(dev_bits[8:1]), 8'hA5);
    check_eq("busy_start_done", n_done - d0, 1);

    // Reset at edge 6 aborts silently.
    d0 = n_done; e0 = n_err;
    send(8'h3C);
    dev_xfer(11, 1'b1, 6);
    step(2 * BITTO);
    check_eq("rst_nodone", n_done - d0, 0);
    check_eq("rst_noerr", n_err - e0, 0);
    check_eq("rst_busy_after", int'(TX_BUSY), 0);
    check_eq("rst_clk_oe_after", int'(PS2_CLK_OE), 0);

    check_eq("never_both", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
